// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg
// Constants shared by the stages of the 5-stage RISC-V pipeline: datapath
// width, the canonical NOP encoding, the default reset PC and the opcode
// values the decode/execute stages switch on.
package riscv_pipe_pkg;

    localparam int          XLEN     = 64;
    localparam logic [31:0] NOP      = 32'h0000_0013;   // addi x0, x0, 0
    localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_0000;

    // Major opcodes used by the pipeline (instr[6:0])
    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b000_0011,   // LD
        OPC_STORE  = 7'b010_0011,   // SD
        OPC_BRANCH = 7'b110_0011,   // BEQ
        OPC_OP     = 7'b011_0011,   // register ALU op
        OPC_OP_IMM = 7'b001_0011    // immediate ALU op
    } opcode_e;

    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_SD  = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;

    // Extract the major opcode field of an instruction word
    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// riscv_fetch_unit_if
// Bundles the fetch stage's bus-facing signals:
//   imem_req/imem_addr/imem_rdata : synchronous instruction memory port
//   redirect/redirect_pc          : flush-and-restart from a later stage
//   id_valid/id_ready/id_instr/id_pc : valid/ready handoff to decode
// Modport master is the fetch unit; slave is memory + downstream pipeline.
interface riscv_fetch_unit_if #(
    parameter int XLEN = riscv_pipe_pkg::XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect, redirect_pc,
        output id_valid, id_instr, id_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect, redirect_pc,
        input  id_valid, id_instr, id_pc,
        output id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
// Generic synchronous FIFO, DEPTH entries (power of two) of WIDTH bits.
// Ports: clock, reset (sync, active-high), flush (clears contents),
//        push/push_data, pop, count (0..DEPTH), head_data (oldest entry).
// The caller must not push when full nor pop when empty.
module fetch_queue #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data
);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en_s;

    // Next pointer/count state; flush overrides any push or pop
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        push_en_s = 1'b0;
        if (flush) begin
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            push_en_s = push;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless outside [rd_ptr, wr_ptr)
    always_ff @(posedge clock) begin
        if (push_en_s && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit
// Instruction fetch stage feeding the IF/ID register. Owns the PC, issues at
// most one word fetch per cycle to a one-cycle-latency memory, buffers the
// returned words with their PCs in fetch_queue and offers the oldest to
// decode over valid/ready. A redirect flushes the queue, drops the response
// in flight and restarts fetch at the new PC on the following cycle.
// Ports: clock, reset (sync, active-high), bus (riscv_fetch_unit_if.master).
module riscv_fetch_unit #(
    parameter int              XLEN     = riscv_pipe_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pipe_pkg::RESET_PC),
    parameter logic [31:0]     NOP      = riscv_pipe_pkg::NOP
) (
    input  logic                      clock,
    input  logic                      reset,
    riscv_fetch_unit_if.master        bus
);
    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam int              SW         = CW + 1;
    localparam logic [SW-1:0]   DEPTH_W    = SW'(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(2'b11);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);
    localparam logic [XLEN-1:0] RESET_AL   = RESET_PC & ALIGN_MASK;

    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    req_pc_q, req_pc_d;
    logic               inflight_q, inflight_d;

    logic [CW-1:0]      count_s;
    logic [32+XLEN-1:0] head_s;
    logic               id_valid_s;
    logic               pop_s;
    logic               push_s;
    logic               issue_s;
    logic [SW-1:0]      credit_s;

    assign id_valid_s = (count_s != {CW{1'b0}});

    // Credit check and fetch issue: queued + in-flight words, minus the one
    // leaving this cycle, must leave room for the word about to be requested
    always_comb begin
        pop_s    = id_valid_s & bus.id_ready;
        credit_s = SW'(count_s) + SW'(inflight_q) - SW'(pop_s);
        push_s   = inflight_q & ~bus.redirect;
        issue_s  = 1'b0;
        if (reset || bus.redirect) begin
            issue_s = 1'b0;
        end else if (credit_s < DEPTH_W) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next PC / in-flight tracking; a redirect also kills the in-flight word
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (bus.redirect) begin
            pc_d = bus.redirect_pc & ALIGN_MASK;
        end else if (issue_s) begin
            pc_d       = pc_q + PC_STEP;
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and request bookkeeping registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_AL;
            req_pc_q   <= {XLEN{1'b0}};
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_queue #(
        .WIDTH (32 + XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (push_s),
        .push_data ({bus.imem_rdata, req_pc_q}),
        .pop       (pop_s),
        .count     (count_s),
        .head_data (head_s)
    );

    // Memory request port
    always_comb begin
        bus.imem_req  = issue_s;
        bus.imem_addr = pc_q;
    end

    // Decode handoff straight from queue storage; a NOP bubble when empty
    always_comb begin
        bus.id_valid = id_valid_s;
        if (id_valid_s) begin
            bus.id_instr = head_s[32+XLEN-1:XLEN];
            bus.id_pc    = head_s[XLEN-1:0];
        end else begin
            bus.id_instr = NOP;
            bus.id_pc    = {XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit
// Directed bench: a one-cycle-latency memory returns addr>>2 for every
// request; inputs change on the falling edge and outputs are checked 1ns later.
module tb_riscv_fetch_unit;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    riscv_fetch_unit_if #(.XLEN(64)) bus ();

    riscv_fetch_unit #(
        .XLEN     (64),
        .DEPTH    (4),
        .RESET_PC (64'h0),
        .NOP      (NOP_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: word at addr is addr>>2, garbage when idle
    always @(posedge clock) begin
        if (bus.imem_req) begin
            bus.imem_rdata <= bus.imem_addr[33:2];
        end else begin
            bus.imem_rdata <= 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [63:0] pc, input logic [31:0] instr);
        chk({tag, "_valid"}, 64'(bus.id_valid), 64'(v));
        chk({tag, "_pc"},    bus.id_pc, pc);
        chk({tag, "_instr"}, 64'(bus.id_instr), 64'(instr));
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [63:0] addr);
        chk({tag, "_req"}, 64'(bus.imem_req), 64'(req));
        if (req) chk({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    // One cycle: apply inputs after the falling edge, settle, return for checks
    task automatic drive(input logic rst, input logic rdr, input logic [63:0] rpc, input logic rdy);
        @(negedge clock);
        reset           = rst;
        bus.redirect    = rdr;
        bus.redirect_pc = rpc;
        bus.id_ready    = rdy;
        #1;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 64'h0;
        bus.id_ready    = 1'b0;
        bus.imem_rdata  = 32'h0;

        // Reset: no request while reset is high
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        chk_req("rst0", 1'b0, 64'h0);
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        chk_req("rst1", 1'b0, 64'h0);

        // Streaming with id_ready held high
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_id("c0", 1'b0, 64'h0, NOP_W);
        chk_req("c0", 1'b1, 64'h0);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_id("c1", 1'b0, 64'h0, NOP_W);
        chk_req("c1", 1'b1, 64'h4);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 64'h0, 1'b1);
            chk_id("stream", 1'b1, 64'(4 * i), 32'(i));
            chk_req("stream", 1'b1, 64'(8 + 4 * i));
        end

        // Backpressure from a fresh reset, DEPTH=4
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 64'h0, 1'b0);
            chk_req("bp_fill", 1'b1, 64'(4 * i));
            if (i >= 2) chk_id("bp_fill", 1'b1, 64'h0, 32'h0);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 64'h0, 1'b0);
            chk_req("bp_full", 1'b0, 64'h0);
            chk_id("bp_hold", 1'b1, 64'h0, 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 64'h0, 1'b1);
            chk_id("bp_drain", 1'b1, 64'(4 * i), 32'(i));
            if (i == 0) chk_req("bp_resume", 1'b1, 64'h10);
        end

        // Flush with 3 queued entries and 1 in flight
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 64'h0, 1'b0);
        drive(1'b0, 1'b1, 64'h100, 1'b0);
        chk_req("fl_t", 1'b0, 64'h0);
        chk_id("fl_t", 1'b1, 64'h0, 32'h0);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_id("fl_t1", 1'b0, 64'h0, NOP_W);
        chk_req("fl_t1", 1'b1, 64'h100);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_id("fl_t2", 1'b0, 64'h0, NOP_W);
        chk_req("fl_t2", 1'b1, 64'h104);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 64'h0, 1'b1);
            chk_id("fl_stream", 1'b1, 64'h100 + 64'(4 * i), 32'h40 + 32'(i));
        end

        // Misaligned redirect target is word-aligned
        drive(1'b0, 1'b1, 64'h103, 1'b1);
        chk_req("mis_t", 1'b0, 64'h0);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_req("mis_t1", 1'b1, 64'h100);
        chk_id("mis_t1", 1'b0, 64'h0, NOP_W);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_id("mis_t2", 1'b0, 64'h0, NOP_W);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_id("mis_t3", 1'b1, 64'h100, 32'h40);

        // PC wrap-around
        drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_req("wrap_t1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_req("wrap_t2", 1'b1, 64'h0);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_id("wrap_t3", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_id("wrap_t4", 1'b1, 64'h0, 32'h0);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_id("wrap_t5", 1'b1, 64'h4, 32'h1);

        // Reset wins over a simultaneous redirect
        drive(1'b1, 1'b1, 64'h200, 1'b1);
        chk_req("rp_rst", 1'b0, 64'h0);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_id("rp_c0", 1'b0, 64'h0, NOP_W);
        chk_req("rp_c0", 1'b1, 64'h0);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_req("rp_c1", 1'b1, 64'h4);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk_id("rp_c2", 1'b1, 64'h0, 32'h0);

        // Fill the queue, then reset mid-stream
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 64'h0, 1'b0);
        chk_req("rf_full", 1'b0, 64'h0);
        chk_id("rf_full", 1'b1, 64'h4, 32'h1);
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        chk_req("rf_rst", 1'b0, 64'h0);
        drive(1'b0, 1'b0, 64'h200, 1'b0);
        chk_id("rf_after", 1'b0, 64'h0, NOP_W);
        chk_req("rf_after", 1'b1, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Instruction fetch stage for the 5-stage RISC-V pipeline, placed directly upstream of the IF/ID register. It owns the PC and issues one word fetch per cycle to a synchronous instruction memory. Returned instructions are buffered, with their PCs, in a small queue, and handed to decode over a valid/ready handshake. A redirect input lets a later branch-resolution or hazard stage flush the queue and restart fetch.

## Interface
- `XLEN`, 64: PC/address width.
- `DEPTH`, 4: instruction queue entries; must be a power of two, ≥2.
- `RESET_PC`, 0: first fetch address after reset.
- `NOP`, 32'h0000_0013: word driven on `id_instr` when no instruction is valid.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  fetch request this cycle.
- `imem_addr`  out  XLEN  byte address of the request; bits [1:0] are always 0.
- `imem_rdata`  in  32  instruction word; valid exactly one cycle after the request; memory always accepts.
- `redirect`  in  1  flush the pipeline front and restart fetch.
- `redirect_pc`  in  XLEN  new PC; bits [1:0] are ignored (treated as 0).
- `id_valid`  out  1  queue head holds an instruction.
- `id_ready`  in  1  decode accepts the head this cycle.
- `id_instr`  out  32  head instruction; `NOP` when `!id_valid`.
- `id_pc`  out  XLEN  PC of the head; 0 when `!id_valid`.

## Operation
- **State:**
  - `pc`: next fetch address.
  - `inflight`: 1 bit; a request was issued last cycle and not killed.
  - `req_pc`: PC of the inflight request.
  - Queue of {instr, pc}, with `count`.
- **pop** = `id_valid & id_ready`.
- **Issue condition:** `!reset & !redirect & (count + inflight - pop < DEPTH)`.
  - On issue: `imem_req`=1, `imem_addr`=`pc`, `pc` ← `pc`+4 (modulo 2^XLEN), `req_pc` ← `pc`, `inflight` ← 1.
  - Otherwise: `inflight` ← 0.
- **Response:** if `inflight` and not killed, push {`imem_rdata`, `req_pc`} at the end of that cycle. The credit rule guarantees the queue never overflows.
- **Redirect cycle:**
  - `pc` ← {`redirect_pc`[XLEN-1:2], 2'b00}.
  - Queue cleared.
  - The `inflight` response arriving this cycle is discarded.
  - No request is issued.
  - A pop in this same cycle counts as completed; decode owns that instruction.
- **Reset:** `pc` ← `RESET_PC`, queue empty, `inflight` ← 0. Reset wins over `redirect`.
- **Simultaneous push and pop:** `count` is unchanged; order is preserved.
- **Full queue** (`count`==`DEPTH`): no request; resumes in the cycle a pop frees credit.
- **Empty queue:** `id_valid`=0, `id_instr`=`NOP`. There is no bypass from `imem_rdata` to the outputs.

## Timing
- **Outputs during/after reset:**
  - `imem_req`=0 while `reset`=1.
  - `id_valid`=0, `id_instr`=`NOP`, `id_pc`=0 in the cycle after reset.
- **Fetch after reset deassert:** first cycle is c0.
  - c0: `imem_req`=1, `imem_addr`=`RESET_PC`.
  - c1: data captured.
  - c2: `id_valid`=1.
- **Redirect** at cycle t:
  - t+1: request to `redirect_pc`.
  - t+3: `id_valid` with that instruction.
  - `id_valid`=0 in t+1 and t+2.
- **Throughput:** with `id_ready` held at 1, one instruction per cycle with no bubbles, for any legal `DEPTH`.
- **Output source:** `id_*` outputs come from queue storage only. The handshake rule is "`id_*` stable while `id_valid & !id_ready`, unless `redirect`".

## Structure
- Shared package `riscv_pipe_pkg`: `XLEN`, `NOP`, opcode constants (LD, SD, BEQ, ALUop), and `RESET_PC` default. The package is shared with the existing pipeline stages.
- Sub-module `fetch_queue`: synchronous FIFO of {instr, pc} with push, pop, flush, count and head outputs. It contains no knowledge of fetch.

## Test plan
- **Streaming:** reset released, `id_ready`=1, memory returns `addr>>2` → `id_pc` = 0, 4, 8, … on consecutive cycles from c2, with `id_instr` = 0, 1, 2, …; no gaps.
- **Backpressure:** `id_ready`=0 for 10 cycles, `DEPTH`=4 → `imem_req` drops once count+inflight=4; `id_pc` holds 0 and `id_instr` is stable. On release, 0, 4, 8, 12, 16 appear in order with nothing lost or duplicated.
- **Flush:** `redirect` to 0x100 with the queue holding 3 entries and 1 inflight → `id_valid`=0 at t+1 and t+2. At t+3, `id_pc`=0x100 and no pre-redirect PC ever appears again.
- **Misaligned redirect:** `redirect_pc`=0x103 → `imem_addr`=0x100 at t+1.
- **Reset priority:** `reset` and `redirect` together, then reset mid-stream with a full queue → next cycle `id_valid`=0 and `imem_req`=0 during reset; fetch restarts at `RESET_PC`, not `redirect_pc`.
- **PC wrap:** redirect to 0xFFFF_FFFF_FFFF_FFFC → `id_pc` sequence 0xFFFF_FFFF_FFFF_FFFC, 0x0, 0x4.
